// File: rtl/fifo_pkg.sv
// Shared defaults and FSM state type for the FIFO burst reader.
package fifo_pkg;
  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned LEN_WIDTH_DEF  = 8;
  localparam int unsigned SKID_DEPTH_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } rd_state_t;
endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order skid buffer; head entry drives the output.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = SKID_DEPTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            count
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;

  assign dout = head;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: the new word lands behind whatever survives the pop.
          if (count == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assert property (@(posedge clock) disable iff (!reset) !(push && !pop && count == FULL));
  assert property (@(posedge clock) disable iff (!reset) !(pop && count == 2'd0));

endmodule

// File: rtl/fifo_reader.sv
// Reads a burst of len words from a latency-1 FIFO and streams them out
// through a 2-entry skid buffer with valid/ready handshaking.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int unsigned SKID_DEPTH = SKID_DEPTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  fifo_empty,
  input  logic                  fifo_wn,
  input  logic [DATA_WIDTH-1:0] fifo_dataout,
  output logic                  fifo_rn,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
);

  rd_state_t            state;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] issued;
  logic                 inflight;
  logic [1:0]           skid_count;
  logic                 pop;
  logic                 accept;
  logic [2:0]           credit;

  assign m_valid = (skid_count != 2'd0);
  assign pop     = m_valid && m_ready;

  // Credit counts the word leaving this cycle so a full-rate stream never bubbles.
  assign credit  = {1'b0, skid_count} + {2'b0, inflight} - {2'b0, pop};
  assign fifo_rn = (state == RUN) && (issued < len_q) && !fifo_empty && (credit < 3'd2);
  assign accept  = fifo_rn && !fifo_wn;

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (SKID_DEPTH)
  ) u_skid (
    .clock (clock),
    .reset (reset),
    .push  (inflight),
    .pop   (pop),
    .din   (fifo_dataout),
    .dout  (m_data),
    .count (skid_count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      len_q    <= '0;
      issued   <= '0;
      inflight <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      inflight <= accept;
      if (accept) issued <= issued + 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            len_q  <= len;
            issued <= '0;
            busy   <= 1'b1;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (issued == len_q) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && skid_count == 2'd1 && !inflight) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: cycle-exact vector table plus
// hand-written sequences for stall, write pre-emption, starvation and reset.
module tb_fifo_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic        fifo_empty;
  logic        fifo_wn = 1'b0;
  logic [15:0] fifo_dataout = 16'd0;
  logic        fifo_rn;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        busy;
  logic        done;

  always #5 clock = ~clock;

  fifo_reader #(
    .DATA_WIDTH (16),
    .LEN_WIDTH  (8),
    .SKID_DEPTH (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .len          (len),
    .fifo_empty   (fifo_empty),
    .fifo_wn      (fifo_wn),
    .fifo_dataout (fifo_dataout),
    .fifo_rn      (fifo_rn),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .busy         (busy),
    .done         (done)
  );

  // FIFO model: registered read data, a write pre-empts a read.
  logic [15:0] fmem [0:63];
  logic [15:0] wdata = 16'd0;
  int          wp = 0;
  int          rp = 0;
  int          rd_acc = 0;

  assign fifo_empty = (wp == rp);

  always @(posedge clock) begin
    if (fifo_wn) begin
      fmem[wp[5:0]] <= wdata;
      wp <= wp + 1;
    end else if (fifo_rn && wp != rp) begin
      fifo_dataout <= fmem[rp[5:0]];
      rp     <= rp + 1;
      rd_acc <= rd_acc + 1;
    end
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_next = 16'd0;
  int          got = 0;
  int          done_seen = 0;
  int          rd_base = 0;
  bit          mon_en = 1'b0;
  bit          chk_out = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    if (mon_en) begin
      if (m_valid && m_ready) begin
        chk("word order", 32'(m_data), 32'(exp_next));
        exp_next++;
        got++;
      end
      if (done) done_seen++;
      if (chk_out)
        chk("outstanding<=2",
            32'((rd_acc - rd_base + ((fifo_rn && !fifo_wn) ? 1 : 0) - got) <= 2), 32'd1);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic push_words(input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_wn = 1'b1;
      wdata   = first + 16'(i);
      step();
    end
    fifo_wn = 1'b0;
  endtask

  task automatic begin_seq(input logic [15:0] first);
    exp_next  = first;
    got       = 0;
    done_seen = 0;
    rd_base   = rd_acc;
    mon_en    = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_seen == 0; i++) step();
    chk("done pulse", 32'(done_seen), 32'd1);
  endtask

  typedef struct {
    logic        start;
    logic [7:0]  len;
    logic        m_ready;
    logic        exp_rn;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  function automatic vec_t mk(logic s, logic [7:0] l, logic r, logic rn, logic v,
                              logic [15:0] d, logic b, logic dn);
    vec_t t;
    t.start = s; t.len = l; t.m_ready = r; t.exp_rn = rn; t.exp_valid = v;
    t.exp_data = d; t.exp_busy = b; t.exp_done = dn;
    return t;
  endfunction

  vec_t vt [16];

  initial begin
    // len=0 burst, then len=8 full-rate burst over a FIFO preloaded with 1..8
    vt[0]  = mk(1, 0, 1, 0, 0, 16'h0000, 0, 0);
    vt[1]  = mk(0, 0, 1, 0, 0, 16'h0000, 1, 1);
    vt[2]  = mk(0, 0, 1, 0, 0, 16'h0000, 0, 0);
    vt[3]  = mk(1, 8, 1, 0, 0, 16'h0000, 0, 0);
    vt[4]  = mk(0, 8, 1, 1, 0, 16'h0000, 1, 0);
    vt[5]  = mk(0, 8, 1, 1, 0, 16'h0000, 1, 0);
    vt[6]  = mk(0, 8, 1, 1, 1, 16'h0001, 1, 0);
    vt[7]  = mk(0, 8, 1, 1, 1, 16'h0002, 1, 0);
    vt[8]  = mk(0, 8, 1, 1, 1, 16'h0003, 1, 0);
    vt[9]  = mk(0, 8, 1, 1, 1, 16'h0004, 1, 0);
    vt[10] = mk(0, 8, 1, 1, 1, 16'h0005, 1, 0);
    vt[11] = mk(0, 8, 1, 1, 1, 16'h0006, 1, 0);
    vt[12] = mk(0, 8, 1, 0, 1, 16'h0007, 1, 0);
    vt[13] = mk(0, 8, 1, 0, 1, 16'h0008, 1, 0);
    vt[14] = mk(0, 8, 1, 0, 0, 16'h0000, 1, 1);
    vt[15] = mk(0, 8, 1, 0, 0, 16'h0000, 0, 0);

    repeat (2) @(posedge clock);
    #1;
    chk("reset fifo_rn", 32'(fifo_rn), 32'd0);
    chk("reset m_valid", 32'(m_valid), 32'd0);
    chk("reset m_data",  32'(m_data),  32'd0);
    chk("reset busy",    32'(busy),    32'd0);
    chk("reset done",    32'(done),    32'd0);
    reset = 1'b1;
    step();

    push_words(16'h0001, 8);
    for (int i = 0; i < 16; i++) begin
      start   = vt[i].start;
      len     = vt[i].len;
      m_ready = vt[i].m_ready;
      @(negedge clock);
      chk($sformatf("v%0d fifo_rn", i), 32'(fifo_rn), 32'(vt[i].exp_rn));
      chk($sformatf("v%0d m_valid", i), 32'(m_valid), 32'(vt[i].exp_valid));
      if (vt[i].exp_valid)
        chk($sformatf("v%0d m_data", i), 32'(m_data), 32'(vt[i].exp_data));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vt[i].exp_busy));
      chk($sformatf("v%0d done", i), 32'(done), 32'(vt[i].exp_done));
      @(posedge clock);
      #1;
    end
    start = 1'b0;

    // Downstream stall: first word held, reads capped at two outstanding.
    push_words(16'h0011, 4);
    begin_seq(16'h0011);
    chk_out = 1'b1;
    m_ready = 1'b0;
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 10 && !m_valid; i++) step();
    chk("stall m_valid", 32'(m_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("stall m_data held", 32'(m_data), 32'h0011);
      chk("stall no read", 32'(fifo_rn), 32'd0);
      step();
    end
    m_ready = 1'b1;
    wait_done(20);
    chk("stall burst words", 32'(got), 32'd4);
    chk_out = 1'b0;

    // Write in the cycle the read first rises: read retried, not counted.
    push_words(16'h0021, 3);
    begin_seq(16'h0021);
    start = 1'b1; len = 8'd3;
    step();
    start = 1'b0;
    fifo_wn = 1'b1; wdata = 16'h0024;
    chk("preempt rn high", 32'(fifo_rn), 32'd1);
    step();
    fifo_wn = 1'b0;
    chk("preempt retry rn", 32'(fifo_rn), 32'd1);
    wait_done(20);
    chk("preempt words", 32'(got), 32'd3);
    chk("preempt fifo left", 32'(wp - rp), 32'd1);

    // Starved FIFO: two words then stall in RUN until more are written.
    push_words(16'h0025, 1);
    begin_seq(16'h0024);
    start = 1'b1; len = 8'd5;
    step();
    start = 1'b0;
    repeat (8) step();
    chk("starve words", 32'(got), 32'd2);
    chk("starve busy", 32'(busy), 32'd1);
    chk("starve no done", 32'(done_seen), 32'd0);
    chk("starve m_valid", 32'(m_valid), 32'd0);
    chk("starve fifo_rn", 32'(fifo_rn), 32'd0);
    push_words(16'h0026, 3);
    wait_done(20);
    chk("starve total", 32'(got), 32'd5);

    // Reset with one word in the skid and one in flight.
    push_words(16'h0041, 3);
    begin_seq(16'h0041);
    m_ready = 1'b0;
    start = 1'b1; len = 8'd3;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre-reset m_valid", 32'(m_valid), 32'd1);
    chk("pre-reset fifo_rn", 32'(fifo_rn), 32'd0);
    reset = 1'b0;
    #1;
    chk("mid reset fifo_rn", 32'(fifo_rn), 32'd0);
    chk("mid reset m_valid", 32'(m_valid), 32'd0);
    chk("mid reset m_data",  32'(m_data),  32'd0);
    chk("mid reset busy",    32'(busy),    32'd0);
    chk("mid reset done",    32'(done),    32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    chk("no done on reset", 32'(done_seen), 32'd0);
    begin_seq(16'h0043);
    m_ready = 1'b1;
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0;
    wait_done(20);
    chk("post-reset words", 32'(got), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
